// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Holds the FSM state encoding used by mem_arbiter.
package mem_arbiter_pkg;

  localparam int MEM_W_ADDR = 32;
  localparam int MEM_W_DATA = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Tracks consecutive data grants made while a fetch waits and decides
// which requester wins the next grant, so a fetch is never starved.
module arb_streak_counter #(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic grant_dm
);

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DM_STREAK);

  logic [2:0] streak;

  assign grant_dm = dm_req & ~(if_req & (streak == STREAK_MAX));

  // Only a data grant made under fetch pressure extends the streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 3'd0;
    end else if (grant_en) begin
      if (grant_dm && if_req) begin
        if (streak != 3'd7) streak <= streak + 3'd1;
      end else begin
        streak <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port memory with a
// three-state handshake FSM; data has priority, bounded by a streak limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err_ack
);

  state_t state, state_nxt;
  logic   grant_en;
  logic   grant_dm;
  logic   sel_dm;

  arb_streak_counter #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_en (grant_en),
    .grant_dm (grant_dm)
  );

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant_en  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: if (mem_ack) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Memory command is latched at grant and held untouched until the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sel_dm    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      err_ack   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (grant_en) begin
        mem_req   <= 1'b1;
        sel_dm    <= grant_dm;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end
      if (state == ST_BUSY && mem_ack) begin
        mem_req <= 1'b0;
        if (sel_dm) begin
          dm_rdata <= mem_rdata;
          dm_ready <= 1'b1;
        end else begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end
      end
      if (mem_ack && state != ST_BUSY) err_ack <= 1'b1;
    end
  end

endmodule
